// File: rtl/interrupt_pkg.sv
// Shared types and sizing for the interrupt responder slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package interrupt_pkg;

  localparam int NUM_SRC = 8;
  localparam int VEC_W   = 3;

  // Handshake phases of one interrupt delivery to the CPU
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_VEC     = 2'd2,
    ST_SERVICE = 2'd3
  } state_t;

endpackage

// File: rtl/priority_encoder8.sv
// Fixed-priority encoder: returns the lowest-index set bit of an 8-bit word.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input every cycle.
module priority_encoder8 (
  input  logic [7:0] in,
  output logic [2:0] index,
  output logic       any
);

  // Scan from the top down so the lowest set bit is the last assignment and wins
  always_comb begin
    index = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (in[i]) index = 3'(i);
    end
    any = |in;
  end

endmodule

// File: rtl/interrupt_responder.sv
// Sticky-status interrupt controller: raises irq, hands out a vector on ack, holds off until eoi.
// Latency: src pulse -> irq two edges later; ack in REQ -> vector_valid on the next cycle.
// Backpressure: new pending sources wait in statout while a vector is being delivered or serviced.
module interrupt_responder #(
  parameter int NUM_SRC = interrupt_pkg::NUM_SRC,
  parameter int VEC_W   = interrupt_pkg::VEC_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] src,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               ack,
  input  logic               eoi,
  output logic               irq,
  output logic [VEC_W-1:0]   vector,
  output logic               vector_valid,
  output logic [NUM_SRC-1:0] statout,
  output logic [NUM_SRC-1:0] intout,
  output logic               in_service
);

  import interrupt_pkg::*;

  state_t             state;
  logic [NUM_SRC-1:0] pending;
  logic [2:0]         winner;
  logic               any_pending;
  logic               ack_take;
  logic [NUM_SRC-1:0] ack_clr;

  assign pending = statout & intout;

  priority_encoder8 u_prio (
    .in    (pending),
    .index (winner),
    .any   (any_pending)
  );

  // An ack only counts while requesting and something is still pending to hand out
  always_comb begin
    ack_take = (state == ST_REQ) && ack && any_pending;
    ack_clr  = '0;
    if (ack_take) ack_clr[winner] = 1'b1;
  end

  // Sticky status: a new event on the same edge as the ack clear keeps the bit set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) statout <= '0;
    else          statout <= (statout & ~ack_clr) | src;
  end

  // Enable register, visible to the winner selection from the next cycle on
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     intout <= '0;
    else if (mask_we) intout <= mask_wdata;
  end

  // Delivery FSM with registered irq / vector / vector_valid / in_service
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      irq          <= 1'b0;
      vector       <= '0;
      vector_valid <= 1'b0;
      in_service   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_pending) begin
            state <= ST_REQ;
            irq   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (ack_take) begin
            state        <= ST_VEC;
            irq          <= 1'b0;
            vector       <= VEC_W'(winner);
            vector_valid <= 1'b1;
            in_service   <= 1'b1;
          end else if (!any_pending) begin
            // Masked or otherwise withdrawn before the CPU answered
            state <= ST_IDLE;
            irq   <= 1'b0;
          end
        end
        ST_VEC: begin
          state        <= ST_SERVICE;
          vector_valid <= 1'b0;
        end
        ST_SERVICE: begin
          if (eoi) begin
            state      <= ST_IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          irq          <= 1'b0;
          vector_valid <= 1'b0;
          in_service   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_responder.sv
// Self-checking bench for interrupt_responder: directed scenarios plus random traffic vs a model.
// Latency: model advances one step per clock edge; outputs compared 1 time unit after each edge.
// Backpressure: n/a.
module tb_interrupt_responder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] src;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       ack;
  logic       eoi;
  logic       irq;
  logic [2:0] vector;
  logic       vector_valid;
  logic [7:0] statout;
  logic [7:0] intout;
  logic       in_service;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  interrupt_responder #(.NUM_SRC(8), .VEC_W(3)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .src          (src),
    .mask_we      (mask_we),
    .mask_wdata   (mask_wdata),
    .ack          (ack),
    .eoi          (eoi),
    .irq          (irq),
    .vector       (vector),
    .vector_valid (vector_valid),
    .statout      (statout),
    .intout       (intout),
    .in_service   (in_service)
  );

  // Behavioural model: phase 0 waiting, 1 requesting, 2 vector cycle, 3 servicing
  int         m_phase;
  logic [7:0] m_stat, m_mask;
  logic [2:0] m_vec;
  logic       m_irq, m_vv, m_ins;

  function automatic int lowest(input logic [7:0] p);
    for (int i = 0; i < 8; i++) if (p[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_stat = 8'h00; m_mask = 8'h00; m_vec = 3'd0;
    m_irq = 1'b0; m_vv = 1'b0; m_ins = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] s, input logic mw, input logic [7:0] wd,
                            input logic a, input logic e);
    logic [7:0] pend;
    logic [7:0] clr;
    int         w;
    pend = m_stat & m_mask;
    w    = lowest(pend);
    clr  = 8'h00;
    case (m_phase)
      0: if (pend != 0) begin m_phase = 1; m_irq = 1'b1; end
      1: begin
        if (a && pend != 0) begin
          m_vec = 3'(w); clr[w] = 1'b1;
          m_vv = 1'b1; m_ins = 1'b1; m_irq = 1'b0; m_phase = 2;
        end else if (pend == 0) begin
          m_irq = 1'b0; m_phase = 0;
        end
      end
      2: begin m_vv = 1'b0; m_phase = 3; end
      default: if (e) begin m_ins = 1'b0; m_phase = 0; end
    endcase
    m_stat = (m_stat & ~clr) | s;
    if (mw) m_mask = wd;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("irq",          8'(irq),          8'(m_irq));
    chk("vector",       8'(vector),       8'(m_vec));
    chk("vector_valid", 8'(vector_valid), 8'(m_vv));
    chk("statout",      statout,          m_stat);
    chk("intout",       intout,           m_mask);
    chk("in_service",   8'(in_service),   8'(m_ins));
  endtask

  // One clock: drive at negedge, advance the model, compare just after the rising edge
  task automatic cyc(input logic [7:0] s, input logic mw, input logic [7:0] wd,
                     input logic a, input logic e);
    @(negedge clk);
    src = s; mask_we = mw; mask_wdata = wd; ack = a; eoi = e;
    model_step(s, mw, wd, a, e);
    @(posedge clk);
    #1;
    compare_all();
    src = 8'h00; mask_we = 1'b0; mask_wdata = 8'h00; ack = 1'b0; eoi = 1'b0;
  endtask

  task automatic idle(); cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b0); endtask

  initial begin
    reset_n = 1'b0; src = 8'h00; mask_we = 1'b0; mask_wdata = 8'h00; ack = 1'b0; eoi = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_irq", 8'(irq), 8'h00);
    chk("rst_statout", statout, 8'h00);
    chk("rst_intout", intout, 8'h00);
    compare_all();

    // Single source through the whole handshake
    cyc(8'h00, 1'b1, 8'h0F, 1'b0, 1'b0);
    cyc(8'h04, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("s1_irq_early", 8'(irq), 8'h00);
    idle();
    chk("s1_irq", 8'(irq), 8'h01);
    cyc(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("s1_vector", 8'(vector), 8'h02);
    chk("s1_vv", 8'(vector_valid), 8'h01);
    chk("s1_stat", statout, 8'h00);
    chk("s1_ins", 8'(in_service), 8'h01);
    idle();
    chk("s1_vv_drop", 8'(vector_valid), 8'h00);
    chk("s1_vec_hold", 8'(vector), 8'h02);
    cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);

    // Two sources: lower index first, the other after eoi
    cyc(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0);
    cyc(8'hA0, 1'b0, 8'h00, 1'b0, 1'b0);
    idle();
    cyc(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("s2_vector5", 8'(vector), 8'h05);
    chk("s2_stat", statout, 8'h80);
    idle();
    idle();
    chk("s2_hold_irq", 8'(irq), 8'h00);
    cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    idle();
    chk("s2_irq_again", 8'(irq), 8'h01);
    cyc(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("s2_vector7", 8'(vector), 8'h07);
    idle();
    cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);

    // Mask withdrawn while requesting
    cyc(8'h10, 1'b0, 8'h00, 1'b0, 1'b0);
    idle();
    chk("s3_irq", 8'(irq), 8'h01);
    cyc(8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
    idle();
    chk("s3_irq_drop", 8'(irq), 8'h00);
    chk("s3_stat", statout, 8'h10);

    // Same-cycle set and ack-clear of the winner
    cyc(8'h08, 1'b1, 8'h08, 1'b0, 1'b0);
    idle();
    cyc(8'h08, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("s4_vector", 8'(vector), 8'h03);
    chk("s4_stat3", 8'(statout[3]), 8'h01);
    idle();
    cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);

    // Asynchronous reset in SERVICE
    idle();
    cyc(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    idle();
    chk("s5_ins_pre", 8'(in_service), 8'h01);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("s5_rst_ins", 8'(in_service), 8'h00);
    chk("s5_rst_vv", 8'(vector_valid), 8'h00);
    chk("s5_rst_vec", 8'(vector), 8'h00);
    chk("s5_rst_stat", statout, 8'h00);
    compare_all();
    @(negedge clk);
    reset_n = 1'b1;
    cyc(8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
    idle();
    idle();
    chk("s5_masked_irq", 8'(irq), 8'h00);

    // ack in IDLE and eoi in REQ are ignored
    cyc(8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("s6_vv_idle_ack", 8'(vector_valid), 8'h00);
    chk("s6_irq", 8'(irq), 8'h01);
    cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("s6_irq_eoi", 8'(irq), 8'h01);
    chk("s6_vv_eoi", 8'(vector_valid), 8'h00);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] s;
      logic       mw;
      s  = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      mw = ($urandom_range(0, 15) == 0);
      cyc(s, mw, 8'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
